// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky
// overflow/underflow. Define FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             awfull,
  output logic             arempty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] C_DEPTH = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] C_AF    = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] C_AE    = AE_LEVEL[ASIZE:0];

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Status is decoded only from the registered level, so request inputs never reach flags.
  assign w_full  = (r_level == C_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_wr_ok = winc & ~w_full;
  assign w_rd_ok = rinc & ~w_empty;

  assign wfull     = w_full;
  assign rempty    = w_empty;
  assign awfull    = (r_level >= C_AF);
  assign arempty   = (r_level <= C_AE);
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (winc & w_full)  r_overflow  <= 1'b1;
      if (rinc & w_empty) r_underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata = r_mem[r_rptr];
`else
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst)          r_rdata <= '0;
    else if (w_rd_ok) r_rdata <= r_mem[r_rptr];
  end

  assign rdata = r_rdata;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo; expectations adapt to FIFO_FWFT_EN.
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull, rempty, awfull, arempty;
  logic [4:0] level;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .awfull(awfull),
    .arempty(arempty), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    winc = 1'b1; wdata = d;
    tick();
    winc = 1'b0;
  endtask

  // Returns the word acknowledged by one rinc pulse, honouring the read mode.
  task automatic pop(output logic [7:0] d);
`ifdef FIFO_FWFT_EN
    d = rdata;
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
`else
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    d = rdata;
`endif
  endtask

  task automatic test_reset;
    do_reset();
    tick();
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty got=%0b exp=1", rempty); end
    total++; if (arempty !== 1'b1) begin bad++; $display("FAIL reset_arempty got=%0b exp=1", arempty); end
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL reset_wfull got=%0b exp=0", wfull); end
    total++; if (awfull !== 1'b0) begin bad++; $display("FAIL reset_awfull got=%0b exp=0", awfull); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%0b exp=0", underflow); end
`ifndef FIFO_FWFT_EN
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
`endif
    $display("test_reset: done");
  endtask

  task automatic test_order;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(i));
    total++; if (level !== 5'd16) begin bad++; $display("FAIL order_level got=%0d exp=16", level); end
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL order_wfull got=%0b exp=1", wfull); end
`ifdef FIFO_FWFT_EN
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL order_fwft_head got=%0h exp=0", rdata); end
`endif
    for (int i = 0; i < 16; i++) begin
      pop(d);
      total++; if (d !== 8'(i)) begin bad++; $display("FAIL order_data idx=%0d got=%0h exp=%0h", i, d, i); end
    end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL order_rempty got=%0b exp=1", rempty); end
    $display("test_order: done");
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    push(8'hAA);
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL ovf_wfull got=%0b exp=1", wfull); end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    for (int i = 0; i < 16; i++) begin
      pop(d);
      total++; if (d !== 8'(8'h10 + i)) begin bad++; $display("FAIL ovf_drain idx=%0d got=%0h exp=%0h", i, d, 8'h10 + i); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_no_underflow got=%0b exp=0", underflow); end
    $display("test_overflow: done");
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    for (int k = 0; k < 20; k++) begin
`ifdef FIFO_FWFT_EN
      d = rdata;
`endif
      winc = 1'b1; rinc = 1'b1; wdata = 8'(8'h48 + k);
      tick();
`ifndef FIFO_FWFT_EN
      d = rdata;
`endif
      total++; if (d !== 8'(8'h40 + k)) begin bad++; $display("FAIL b2b_data k=%0d got=%0h exp=%0h", k, d, 8'h40 + k); end
      total++; if (level !== 5'd8) begin bad++; $display("FAIL b2b_level k=%0d got=%0d exp=8", k, level); end
    end
    winc = 1'b0; rinc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop(d);
      total++; if (d !== 8'(8'h54 + i)) begin bad++; $display("FAIL b2b_drain idx=%0d got=%0h exp=%0h", i, d, 8'h54 + i); end
    end
    $display("test_back_to_back: done");
  endtask

  task automatic test_thresholds;
    logic [7:0] d;
    do_reset();
    for (int l = 0; l <= 16; l++) begin
      total++; if (level !== 5'(l)) begin bad++; $display("FAIL thr_up_level l=%0d got=%0d", l, level); end
      total++; if (arempty !== (l <= 4)) begin bad++; $display("FAIL thr_up_arempty l=%0d got=%0b exp=%0b", l, arempty, l <= 4); end
      total++; if (awfull !== (l >= 12)) begin bad++; $display("FAIL thr_up_awfull l=%0d got=%0b exp=%0b", l, awfull, l >= 12); end
      if (l < 16) push(8'(l));
    end
    for (int l = 15; l >= 0; l--) begin
      pop(d);
      total++; if (level !== 5'(l)) begin bad++; $display("FAIL thr_dn_level l=%0d got=%0d", l, level); end
      total++; if (arempty !== (l <= 4)) begin bad++; $display("FAIL thr_dn_arempty l=%0d got=%0b exp=%0b", l, arempty, l <= 4); end
      total++; if (awfull !== (l >= 12)) begin bad++; $display("FAIL thr_dn_awfull l=%0d got=%0b exp=%0b", l, awfull, l >= 12); end
    end
    $display("test_thresholds: done");
  endtask

  task automatic test_underflow_reset;
    do_reset();
    winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
    tick();
    winc = 1'b0; rinc = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%0b exp=1", underflow); end
    total++; if (level !== 5'd1) begin bad++; $display("FAIL unf_level got=%0d exp=1", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL unf_no_overflow got=%0b exp=0", overflow); end
`ifdef FIFO_FWFT_EN
    total++; if (rdata !== 8'h77) begin bad++; $display("FAIL unf_rdata got=%0h exp=77", rdata); end
`else
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL unf_rdata got=%0h exp=0", rdata); end
`endif
    for (int i = 0; i < 6; i++) push(8'(8'h80 + i));
    total++; if (level !== 5'd7) begin bad++; $display("FAIL mid_level got=%0d exp=7", level); end
    rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    tick();
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    total++; if (level !== 5'd0) begin bad++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL mid_rst_rempty got=%0b exp=1", rempty); end
    total++; if (arempty !== 1'b1) begin bad++; $display("FAIL mid_rst_arempty got=%0b exp=1", arempty); end
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL mid_rst_wfull got=%0b exp=0", wfull); end
    total++; if (awfull !== 1'b0) begin bad++; $display("FAIL mid_rst_awfull got=%0b exp=0", awfull); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL mid_rst_underflow got=%0b exp=0", underflow); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_overflow got=%0b exp=0", overflow); end
`ifndef FIFO_FWFT_EN
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_rst_rdata got=%0h exp=0", rdata); end
`endif
    $display("test_underflow_reset: done");
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    test_reset();
    test_order();
    test_overflow();
    test_back_to_back();
    test_thresholds();
    test_underflow_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
